// File: rtl/ob_cnt_ctl_if.sv
// Query/command/response bundle for the order-book count sequencer.
// The 'slave' modport is the sequencer's view. The 'master' modport is the
// surrounding logic: the query source, the count units and the response sink.
interface ob_cnt_ctl_if #(
  parameter int PRICE_W = 20,
  parameter int QTY_W   = 16,
  parameter int ACC_W   = 24
);
  // query channel
  logic               req_vld;
  logic               req_rdy;
  logic               req_is_ask;
  logic [PRICE_W-1:0] req_price;
  logic [QTY_W-1:0]   req_quantity;
  // count-unit command / status
  logic               ask_cmd_vld;
  logic               bid_cmd_vld;
  logic [PRICE_W-1:0] cmd_price;
  logic               ask_busy;
  logic               bid_busy;
  logic [ACC_W-1:0]   ask_quantity;
  logic [ACC_W-1:0]   bid_quantity;
  // response channel
  logic               rsp_vld;
  logic               rsp_rdy;
  logic               rsp_is_ask;
  logic [ACC_W-1:0]   rsp_quantity;
  logic               rsp_fill_ok;
  logic               rsp_err;

  modport slave (
    input  req_vld, req_is_ask, req_price, req_quantity,
    output req_rdy,
    output ask_cmd_vld, bid_cmd_vld, cmd_price,
    input  ask_busy, bid_busy, ask_quantity, bid_quantity,
    output rsp_vld, rsp_is_ask, rsp_quantity, rsp_fill_ok, rsp_err,
    input  rsp_rdy
  );

  modport master (
    output req_vld, req_is_ask, req_price, req_quantity,
    input  req_rdy,
    input  ask_cmd_vld, bid_cmd_vld, cmd_price,
    output ask_busy, bid_busy, ask_quantity, bid_quantity,
    input  rsp_vld, rsp_is_ask, rsp_quantity, rsp_fill_ok, rsp_err,
    output rsp_rdy
  );
endinterface

// File: rtl/ob_cnt_ctl.sv
// Order-book count sequencer. It accepts one "quantity available at price"
// query, pulses a count command to the ask or bid unit, waits for that unit
// to go idle (bounded by TIMEOUT), and returns the quantity, a fill flag and
// an error flag.
// Optional build macro OB_CNT_CTL_STATS_EN adds saturating response and
// timeout counters (stat_qry_cnt, stat_tmo_cnt).
module ob_cnt_ctl #(
  parameter int PRICE_W = 20,
  parameter int QTY_W   = 16,
  parameter int ACC_W   = 24,
  parameter int TIMEOUT = 64   // WAIT-cycle limit, must be >= 2
) (
  input  logic        clk,
  input  logic        rst,     // asynchronous, active-low
`ifdef OB_CNT_CTL_STATS_EN
  output logic [15:0] stat_qry_cnt,
  output logic [15:0] stat_tmo_cnt,
`endif
  ob_cnt_ctl_if.slave bus
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam int CMP_W = (ACC_W > QTY_W) ? ACC_W : QTY_W;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t             state_q, state_d;
  logic               rdy_q, rdy_d;
  logic               is_ask_q, is_ask_d;
  logic [PRICE_W-1:0] price_q, price_d;
  logic [QTY_W-1:0]   qty_q, qty_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ACC_W-1:0]   rqty_q, rqty_d;
  logic               fill_q, fill_d;
  logic               err_q, err_d;

  logic               sel_busy;
  logic [ACC_W-1:0]   sel_qty;
  logic               accept;
  logic               rsp_hs;

  // Unsigned compare with both operands zero-extended to a common width.
  function automatic logic fill_possible(input logic [ACC_W-1:0] acc,
                                         input logic [QTY_W-1:0] need);
    return CMP_W'(acc) >= CMP_W'(need);
  endfunction

  // Only the side chosen at accept time is observed.
  assign sel_busy = is_ask_q ? bus.ask_busy     : bus.bid_busy;
  assign sel_qty  = is_ask_q ? bus.ask_quantity : bus.bid_quantity;

  // rdy_q is registered, so req_rdy never depends on req_vld. It is only
  // high in IDLE.
  assign accept = rdy_q & bus.req_vld;
  assign rsp_hs = (state_q == S_RESP) & bus.rsp_rdy;

  // Next-state, capture and timeout-counter logic.
  always_comb begin
    state_d  = state_q;
    is_ask_d = is_ask_q;
    price_d  = price_q;
    qty_d    = qty_q;
    cnt_d    = cnt_q;
    rqty_d   = rqty_q;
    fill_d   = fill_q;
    err_d    = err_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          is_ask_d = bus.req_is_ask;
          price_d  = bus.req_price;
          qty_d    = bus.req_quantity;
          state_d  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        // An idle unit takes priority over a timeout in the same cycle.
        if (!sel_busy) begin
          rqty_d  = sel_qty;
          fill_d  = fill_possible(sel_qty, qty_q);
          err_d   = 1'b0;
          state_d = S_RESP;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          rqty_d  = '0;
          fill_d  = 1'b0;
          err_d   = 1'b1;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (bus.rsp_rdy) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    rdy_d = (state_d == S_IDLE);
  end

  // State and captured-data registers. Reset clears all of them.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      rdy_q    <= 1'b0;
      is_ask_q <= 1'b0;
      price_q  <= '0;
      qty_q    <= '0;
      cnt_q    <= '0;
      rqty_q   <= '0;
      fill_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rdy_q    <= rdy_d;
      is_ask_q <= is_ask_d;
      price_q  <= price_d;
      qty_q    <= qty_d;
      cnt_q    <= cnt_d;
      rqty_q   <= rqty_d;
      fill_q   <= fill_d;
      err_q    <= err_d;
    end
  end

  assign bus.req_rdy      = rdy_q;
  assign bus.ask_cmd_vld  = (state_q == S_ISSUE) &  is_ask_q;
  assign bus.bid_cmd_vld  = (state_q == S_ISSUE) & ~is_ask_q;
  assign bus.cmd_price    = price_q;
  assign bus.rsp_vld      = (state_q == S_RESP);
  assign bus.rsp_is_ask   = is_ask_q;
  assign bus.rsp_quantity = rqty_q;
  assign bus.rsp_fill_ok  = fill_q;
  assign bus.rsp_err      = err_q;

`ifdef OB_CNT_CTL_STATS_EN
  logic [15:0] stat_qry_q;
  logic [15:0] stat_tmo_q;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Saturating counts of completed responses and of timed-out responses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_qry_q <= '0;
      stat_tmo_q <= '0;
    end else if (rsp_hs) begin
      stat_qry_q <= sat_inc(stat_qry_q);
      if (err_q) stat_tmo_q <= sat_inc(stat_tmo_q);
    end
  end

  assign stat_qry_cnt = stat_qry_q;
  assign stat_tmo_cnt = stat_tmo_q;
`endif

endmodule

// File: tb/tb_ob_cnt_ctl.sv
// Directed bench for ob_cnt_ctl. It covers ask/bid queries, fill-flag
// boundaries, the timeout path, response backpressure and reset during WAIT.
module tb_ob_cnt_ctl;
  localparam int PRICE_W = 20;
  localparam int QTY_W   = 16;
  localparam int ACC_W   = 24;
  localparam int TIMEOUT = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_total = 0;
  int   n_pass  = 0;

  ob_cnt_ctl_if #(.PRICE_W(PRICE_W), .QTY_W(QTY_W), .ACC_W(ACC_W)) bus ();

`ifdef OB_CNT_CTL_STATS_EN
  logic [15:0] stat_qry_cnt;
  logic [15:0] stat_tmo_cnt;
`endif

  ob_cnt_ctl #(.PRICE_W(PRICE_W), .QTY_W(QTY_W), .ACC_W(ACC_W), .TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .rst          (rst_n),
`ifdef OB_CNT_CTL_STATS_EN
    .stat_qry_cnt (stat_qry_cnt),
    .stat_tmo_cnt (stat_tmo_cnt),
`endif
    .bus          (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_busy(input logic side_ask, input logic v);
    if (side_ask) bus.ask_busy = v;
    else          bus.bid_busy = v;
  endtask

  // Present one query in IDLE and check the ISSUE-cycle command pulse.
  task automatic accept(input string tag, input logic is_ask, input int price, input int qty);
    check({tag, ":pre_rdy"}, 32'(bus.req_rdy), 1);
    bus.req_vld      = 1'b1;
    bus.req_is_ask   = is_ask;
    bus.req_price    = PRICE_W'(price);
    bus.req_quantity = QTY_W'(qty);
    tick();
    bus.req_vld      = 1'b0;
    bus.req_price    = 20'hFFFFF;     // must not leak into cmd_price
    bus.req_quantity = 16'h0000;
    check({tag, ":ask_cmd"}, 32'(bus.ask_cmd_vld), 32'(is_ask));
    check({tag, ":bid_cmd"}, 32'(bus.bid_cmd_vld), 32'(!is_ask));
    check({tag, ":cmd_price"}, 32'(bus.cmd_price), price);
    check({tag, ":rdy_issue"}, 32'(bus.req_rdy), 0);
  endtask

  // From the ISSUE point, hold the selected busy for 'hold' cycles, then
  // count cycles until rsp_vld. Bounded, and no extra command pulses allowed.
  task automatic wait_rsp(input string tag, input logic side_ask, input int hold, input int exp_lat);
    int lat    = 0;
    int pulses = 0;
    if (hold > 0) set_busy(side_ask, 1'b1);
    for (int i = 1; i <= exp_lat + 5 && lat == 0; i++) begin
      tick();
      if (bus.ask_cmd_vld || bus.bid_cmd_vld) pulses++;
      if (bus.rsp_vld) lat = i;
      else if (i >= hold) set_busy(side_ask, 1'b0);
    end
    set_busy(side_ask, 1'b0);
    check({tag, ":latency"}, lat, exp_lat);
    check({tag, ":extra_pulses"}, pulses, 0);
  endtask

  task automatic expect_rsp(input string tag, input logic is_ask, input int qty,
                            input logic fill, input logic err, input int price);
    check({tag, ":rsp_vld"}, 32'(bus.rsp_vld), 1);
    check({tag, ":is_ask"}, 32'(bus.rsp_is_ask), 32'(is_ask));
    check({tag, ":quantity"}, 32'(bus.rsp_quantity), qty);
    check({tag, ":fill_ok"}, 32'(bus.rsp_fill_ok), 32'(fill));
    check({tag, ":err"}, 32'(bus.rsp_err), 32'(err));
    check({tag, ":cmd_price_hold"}, 32'(bus.cmd_price), price);
    check({tag, ":rdy_resp"}, 32'(bus.req_rdy), 0);
  endtask

  task automatic handshake(input string tag);
    bus.rsp_rdy = 1'b1;
    tick();
    bus.rsp_rdy = 1'b0;
    check({tag, ":vld_drop"}, 32'(bus.rsp_vld), 0);
    check({tag, ":rdy_back"}, 32'(bus.req_rdy), 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_vld      = 1'b0;
    bus.req_is_ask   = 1'b0;
    bus.req_price    = '0;
    bus.req_quantity = '0;
    bus.ask_busy     = 1'b0;
    bus.bid_busy     = 1'b0;
    bus.ask_quantity = '0;
    bus.bid_quantity = '0;
    bus.rsp_rdy      = 1'b0;

    // Reset state
    #2;
    check("rst:req_rdy", 32'(bus.req_rdy), 0);
    check("rst:rsp_vld", 32'(bus.rsp_vld), 0);
    check("rst:cmd", 32'(bus.ask_cmd_vld | bus.bid_cmd_vld), 0);
    check("rst:cmd_price", 32'(bus.cmd_price), 0);
    check("rst:rsp_qty", 32'(bus.rsp_quantity), 0);
    check("rst:err_fill", 32'({bus.rsp_err, bus.rsp_fill_ok}), 0);
    tick();
    tick();
    check("rst_hold:req_rdy", 32'(bus.req_rdy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("post_rst:req_rdy", 32'(bus.req_rdy), 1);
    check("post_rst:rsp_vld", 32'(bus.rsp_vld), 0);
`ifdef OB_CNT_CTL_STATS_EN
    check("stat:init_qry", 32'(stat_qry_cnt), 0);
    check("stat:init_tmo", 32'(stat_tmo_cnt), 0);
`endif

    // Ask query: best-case latency, unselected bid side busy and ignored
    bus.ask_quantity = 24'd80;
    bus.bid_quantity = 24'd7;
    bus.bid_busy     = 1'b1;
    accept("ask", 1'b1, 'h00105, 50);
    wait_rsp("ask", 1'b1, 1, 2);
    expect_rsp("ask", 1'b1, 80, 1'b1, 1'b0, 'h00105);
    handshake("ask");
    bus.bid_busy = 1'b0;

    // Bid query, 99 < 100, with the unselected ask side busy
    bus.bid_quantity = 24'd99;
    bus.ask_busy     = 1'b1;
    accept("bid100", 1'b0, 'h00200, 100);
    wait_rsp("bid100", 1'b0, 3, 4);
    expect_rsp("bid100", 1'b0, 99, 1'b0, 1'b0, 'h00200);
    handshake("bid100");

    // Bid query, equal quantities
    accept("bid99", 1'b0, 'h00200, 99);
    wait_rsp("bid99", 1'b0, 0, 2);
    expect_rsp("bid99", 1'b0, 99, 1'b1, 1'b0, 'h00200);
    handshake("bid99");
    bus.ask_busy = 1'b0;

    // Zero-extension boundary: accumulated wider than requested quantity
    bus.ask_quantity = 24'h010000;
    accept("wide", 1'b1, 'h00301, 'hFFFF);
    wait_rsp("wide", 1'b1, 0, 2);
    expect_rsp("wide", 1'b1, 'h010000, 1'b1, 1'b0, 'h00301);
    handshake("wide");
    bus.ask_quantity = 24'h00FFFE;
    accept("narrow", 1'b1, 'h00302, 'hFFFF);
    wait_rsp("narrow", 1'b1, 0, 2);
    expect_rsp("narrow", 1'b1, 'hFFFE, 1'b0, 1'b0, 'h00302);
    handshake("narrow");

    // Timeout: busy never falls, 64 WAIT cycles then abort
    bus.bid_quantity = 24'd55;
    accept("tmo", 1'b0, 'h12345, 10);
    wait_rsp("tmo", 1'b0, 1000, TIMEOUT + 1);
    expect_rsp("tmo", 1'b0, 0, 1'b0, 1'b1, 'h12345);
    handshake("tmo");

    // Busy falls on the 64th WAIT cycle: capture wins over timeout
    accept("late", 1'b0, 'h12346, 10);
    wait_rsp("late", 1'b0, TIMEOUT, TIMEOUT + 1);
    expect_rsp("late", 1'b0, 55, 1'b1, 1'b0, 'h12346);
    handshake("late");
`ifdef OB_CNT_CTL_STATS_EN
    check("stat:qry_7", 32'(stat_qry_cnt), 7);
    check("stat:tmo_1", 32'(stat_tmo_cnt), 1);
`endif

    // Backpressure, with a second query waiting
    bus.ask_quantity = 24'd30;
    accept("bp", 1'b1, 'h00777, 40);
    wait_rsp("bp", 1'b1, 0, 2);
    expect_rsp("bp", 1'b1, 30, 1'b0, 1'b0, 'h00777);
    bus.ask_quantity = 24'd999;
    bus.req_vld      = 1'b1;
    bus.req_is_ask   = 1'b0;
    bus.req_price    = 20'h00888;
    bus.req_quantity = 16'd5;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp:rsp_vld", 32'(bus.rsp_vld), 1);
      check("bp:qty_stable", 32'(bus.rsp_quantity), 30);
      check("bp:req_rdy", 32'(bus.req_rdy), 0);
      check("bp:no_cmd", 32'(bus.ask_cmd_vld | bus.bid_cmd_vld), 0);
    end
    bus.rsp_rdy = 1'b1;
    tick();
    bus.rsp_rdy = 1'b0;
    check("bp:vld_drop", 32'(bus.rsp_vld), 0);
    check("bp:rdy_back", 32'(bus.req_rdy), 1);
    check("bp:no_cmd_hs", 32'(bus.ask_cmd_vld | bus.bid_cmd_vld), 0);
    tick();
    bus.req_vld = 1'b0;
    check("bp2:bid_cmd", 32'(bus.bid_cmd_vld), 1);
    check("bp2:ask_cmd", 32'(bus.ask_cmd_vld), 0);
    check("bp2:cmd_price", 32'(bus.cmd_price), 'h00888);
    wait_rsp("bp2", 1'b0, 0, 2);
    expect_rsp("bp2", 1'b0, 55, 1'b1, 1'b0, 'h00888);
    handshake("bp2");

    // Asynchronous reset during WAIT
    accept("rstw", 1'b1, 'h00321, 1);
    bus.ask_busy = 1'b1;
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("rstw:req_rdy", 32'(bus.req_rdy), 0);
    check("rstw:rsp_vld", 32'(bus.rsp_vld), 0);
    check("rstw:cmd_price", 32'(bus.cmd_price), 0);
    check("rstw:cmd", 32'(bus.ask_cmd_vld | bus.bid_cmd_vld), 0);
    check("rstw:rsp_qty", 32'(bus.rsp_quantity), 0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.ask_busy = 1'b0;
    tick();
    check("rstw:rdy_after", 32'(bus.req_rdy), 1);
    check("rstw:no_reissue", 32'(bus.ask_cmd_vld | bus.bid_cmd_vld), 0);
    bus.ask_quantity = 24'd5;
    accept("after", 1'b1, 'h00042, 5);
    wait_rsp("after", 1'b1, 0, 2);
    expect_rsp("after", 1'b1, 5, 1'b1, 1'b0, 'h00042);
    handshake("after");

`ifdef OB_CNT_CTL_STATS_EN
    check("stat:qry_after_rst", 32'(stat_qry_cnt), 1);
    check("stat:tmo_after_rst", 32'(stat_tmo_cnt), 0);
    force dut.stat_qry_q = 16'hFFFE;
    force dut.stat_tmo_q = 16'hFFFE;
    #1;
    release dut.stat_qry_q;
    release dut.stat_tmo_q;
    for (int k = 0; k < 2; k++) begin
      accept("sat", 1'b0, 'h00999, 1);
      wait_rsp("sat", 1'b0, 1000, TIMEOUT + 1);
      handshake("sat");
      check("stat:qry_sat", 32'(stat_qry_cnt), 'hFFFF);
      check("stat:tmo_sat", 32'(stat_tmo_cnt), 'hFFFF);
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
